// File: rtl/mult36_arbiter.sv
// Round-robin front end for one shared 36x36 signed multiplier.
// Up to NREQ requesters compete for the multiplier. A {valid, id} tag rides
// alongside the multiplier pipeline so each product returns with its owner.
// A single response register holds each result until the consumer takes it.
// While the response is held, the multiplier and the tag pipeline freeze
// together through m_ce, so nothing is lost.
//
// Handshake rules (all ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. A valid signal never depends on the matching
// ready. req_ready depends on req_valid and on the response stall. resp_valid
// stays high, with resp_id/resp_data stable, until resp_ready is seen.
module mult36_arbiter #(
    parameter int  NREQ = 4,
    parameter int  LAT  = 1,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*36-1:0] req_a,
    input  logic [NREQ*36-1:0] req_b,
    output logic               m_ce,
    output logic               m_valid_in,
    output logic [35:0]        m_data_a,
    output logic [35:0]        m_data_b,
    input  logic               m_valid_out,
    input  logic [71:0]        m_result,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IW-1:0]      resp_id,
    output logic [71:0]        resp_data,
    output logic               busy,
    output logic               proto_err
);

    logic            stall;
    logic [IW-1:0]   rr_ptr;
    logic [NREQ-1:0] req_rot;
    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic [IW:0]     idx_sum;
    logic            grant_ok;
    logic [LAT-1:0]  tag_v;
    logic [IW-1:0]   tag_id [LAT];

    // A held response that is not being taken freezes the whole datapath.
    assign stall = resp_valid & ~resp_ready;
    assign m_ce  = ~stall;

    // Round-robin search: rotate the requests so rr_ptr is at bit 0. The
    // loop runs downward, so the lowest set bit (the nearest requester) is
    // the one left in grant_idx.
    always_comb begin
        req_rot     = NREQ'({req_valid, req_valid} >> rr_ptr);
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_sum     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_found = 1'b1;
                idx_sum     = {1'b0, rr_ptr} + (IW+1)'(k);
                if (idx_sum >= (IW+1)'(NREQ)) begin
                    idx_sum = idx_sum - (IW+1)'(NREQ);
                end
                grant_idx = idx_sum[IW-1:0];
            end
        end
    end

    // Nothing is granted while stalled or while reset is asserted.
    assign grant_ok   = grant_found & ~stall & rstn;
    assign m_valid_in = grant_ok;

    // Steer the granted operands to the multiplier. Outputs are zero when there is no grant.
    always_comb begin
        req_ready = '0;
        m_data_a  = '0;
        m_data_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_ok && (grant_idx == IW'(i))) begin
                req_ready[i] = 1'b1;
                m_data_a     = req_a[i*36 +: 36];
                m_data_b     = req_b[i*36 +: 36];
            end
        end
    end

    // The pointer moves past the winner only when an operand is actually accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (grant_ok) begin
            rr_ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // The tag pipeline mirrors the multiplier depth and freezes with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else if (m_ce) begin
            tag_v[0]  <= m_valid_in;
            tag_id[0] <= grant_idx;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // The response register takes the tag head and the product unless stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else if (!stall) begin
            resp_valid <= tag_v[LAT-1];
            resp_id    <= tag_id[LAT-1];
            resp_data  <= m_result;
        end
    end

    // Sticky flag: the multiplier's valid disagrees with the tag we expect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            proto_err <= 1'b0;
        end else if (m_ce && (m_valid_out != tag_v[LAT-1])) begin
            proto_err <= 1'b1;
        end
    end

    assign busy = resp_valid | (|tag_v);

endmodule

// File: tb/tb_mult36_arbiter.sv
// Bench for mult36_arbiter with a behavioural multiplier and a
// transaction-level reference model checked on every falling edge.
module tb_mult36_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 1;
    localparam int IW   = 2;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*36-1:0] req_a;
    logic [NREQ*36-1:0] req_b;
    logic               m_ce;
    logic               m_valid_in;
    logic [35:0]        m_data_a;
    logic [35:0]        m_data_b;
    logic               m_valid_out;
    logic [71:0]        m_result;
    logic               resp_valid;
    logic               resp_ready;
    logic [IW-1:0]      resp_id;
    logic [71:0]        resp_data;
    logic               busy;
    logic               proto_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;
    int n_resp   = 0;

    // clock / reset
    always #5 clk = ~clk;

    mult36_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .m_ce(m_ce), .m_valid_in(m_valid_in),
        .m_data_a(m_data_a), .m_data_b(m_data_b),
        .m_valid_out(m_valid_out), .m_result(m_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data),
        .busy(busy), .proto_err(proto_err)
    );

    function automatic logic [71:0] mul36(input logic [35:0] a, input logic [35:0] b);
        logic signed [71:0] ea;
        logic signed [71:0] eb;
        ea = $signed(a);
        eb = $signed(b);
        return ea * eb;
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Shared multiplier: a pure LAT-deep pipeline that holds when ce is low.
    logic        mv [LAT];
    logic [71:0] mp [LAT];
    logic        force_vo;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin mv[i] <= 1'b0; mp[i] <= '0; end
        end else if (m_ce) begin
            mv[0] <= m_valid_in;
            mp[0] <= mul36(m_data_a, m_data_b);
            for (int i = 1; i < LAT; i++) begin mv[i] <= mv[i-1]; mp[i] <= mp[i-1]; end
        end
    end
    assign m_valid_out = mv[LAT-1] | force_vo;
    assign m_result    = mp[LAT-1];

    // Reference model: operations in flight with their pipeline age, plus
    // the held response and the round-robin pointer.
    typedef struct {
        int          id;
        logic [71:0] prod;
        int          stage;
    } op_t;
    op_t         fl[$];
    int          m_rr    = 0;
    bit          m_rv    = 0;
    int          m_rid   = 0;
    logic [71:0] m_rdata = '0;
    bit          m_perr  = 0;

    always @(negedge clk) begin : cmp
        int              g;
        int              idx;
        bit              stall;
        bit              tagv;
        logic [NREQ-1:0] er;
        op_t             nq[$];
        op_t             o;
        if (!rstn) begin
            chk("rst_req_ready", 72'(req_ready), 72'(0));
            chk("rst_m_valid_in", 72'(m_valid_in), 72'(0));
            chk("rst_m_ce", 72'(m_ce), 72'(1));
            chk("rst_resp_valid", 72'(resp_valid), 72'(0));
            chk("rst_resp_id", 72'(resp_id), 72'(0));
            chk("rst_resp_data", resp_data, 72'(0));
            chk("rst_busy", 72'(busy), 72'(0));
            chk("rst_proto_err", 72'(proto_err), 72'(0));
            fl = {};
            m_rr = 0; m_rv = 0; m_rid = 0; m_rdata = '0; m_perr = 0;
        end else begin
            stall = m_rv && !resp_ready;
            g = -1;
            if (!stall) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_rr + k) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("m_ce", 72'(m_ce), 72'(!stall));
            chk("req_ready", 72'(req_ready), 72'(er));
            chk("m_valid_in", 72'(m_valid_in), 72'(g >= 0));
            if (g >= 0) begin
                chk("m_data_a", 72'(m_data_a), 72'(req_a[g*36 +: 36]));
                chk("m_data_b", 72'(m_data_b), 72'(req_b[g*36 +: 36]));
            end else if (!stall) begin
                chk("m_data_a_idle", 72'(m_data_a), 72'(0));
                chk("m_data_b_idle", 72'(m_data_b), 72'(0));
            end
            chk("resp_valid", 72'(resp_valid), 72'(m_rv));
            if (m_rv) begin
                chk("resp_id", 72'(resp_id), 72'(m_rid));
                chk("resp_data", resp_data, m_rdata);
            end
            chk("busy", 72'(busy), 72'(m_rv || fl.size() > 0));
            chk("proto_err", 72'(proto_err), 72'(m_perr));
            // advance the model across the coming rising edge
            if (!stall) begin
                tagv = 0;
                foreach (fl[i]) if (fl[i].stage == LAT - 1) tagv = 1;
                if (m_valid_out !== tagv) m_perr = 1;
                m_rv = 0;
                nq = {};
                foreach (fl[i]) begin
                    o = fl[i];
                    if (o.stage == LAT - 1) begin
                        m_rv = 1; m_rid = o.id; m_rdata = o.prod;
                    end else begin
                        o.stage++;
                        nq.push_back(o);
                    end
                end
                if (g >= 0) begin
                    o.id = g; o.prod = mul36(req_a[g*36 +: 36], req_b[g*36 +: 36]); o.stage = 0;
                    nq.push_back(o);
                    m_rr = (g + 1) % NREQ;
                end
                fl = nq;
            end
        end
    end

    // transfer counters for the loss/duplication check
    always @(negedge clk) begin
        if (rstn) begin
            if (|req_ready) n_acc++;
            if (resp_valid && resp_ready) n_resp++;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [35:0] a, input logic [35:0] b);
        req_a[i*36 +: 36] = a;
        req_b[i*36 +: 36] = b;
    endtask

    task automatic do_reset(input int n);
        step();
        rstn = 1'b0;
        repeat (n) step();
        rstn = 1'b1;
    endtask

    // One lone request; checks acceptance, latency and the product literally.
    task automatic single_op(input string name, input int id, input logic [35:0] a,
                             input logic [35:0] b, input logic [71:0] exp);
        bit got;
        int lat;
        set_op(id, a, b);
        req_valid = '0;
        req_valid[id] = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
            else step();
        end
        chk({name, "_accept"}, 72'(got), 72'(1));
        step();
        req_valid = '0;
        got = 0;
        lat = 0;
        for (int t = 1; t <= 20 && !got; t++) begin
            @(negedge clk);
            if (resp_valid) begin got = 1; lat = t; end
            else step();
        end
        chk({name, "_resp_seen"}, 72'(got), 72'(1));
        chk({name, "_latency"}, 72'(lat), 72'(LAT + 1));
        chk({name, "_id"}, 72'(resp_id), 72'(id));
        chk({name, "_data"}, resp_data, exp);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          grants[5];
        int          exp_g[5];
        int          cnt;
        logic [71:0] hold_data;
        logic [IW-1:0] hold_id;
        exp_g = '{0, 1, 2, 3, 0};

        rstn = 1'b0;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b1;
        force_vo = 1'b0;

        // reset holds grants off even with every requester valid
        repeat (3) step();
        @(negedge clk);
        chk("reset_req_ready", 72'(req_ready), 72'(0));
        chk("reset_m_valid_in", 72'(m_valid_in), 72'(0));
        chk("reset_m_ce", 72'(m_ce), 72'(1));
        step();
        req_valid = '0;
        rstn = 1'b1;
        step();

        // single request from requester 2
        single_op("single", 2, 36'sd123456, -36'sd789, -72'sd97406784);

        // all four streaming from a fresh pointer
        do_reset(2);
        for (int i = 0; i < NREQ; i++) set_op(i, 36'(1000 * (i + 1) + 7), -36'(i + 3));
        n_acc = 0;
        n_resp = 0;
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            grants[c] = oh_idx(req_ready);
            step();
        end
        for (int c = 0; c < 5; c++) chk($sformatf("rr_grant_%0d", c), 72'(grants[c]), 72'(exp_g[c]));
        repeat (3) step();

        // backpressure for five cycles with a response held
        resp_ready = 1'b0;
        @(negedge clk);
        hold_data = resp_data;
        hold_id = resp_id;
        chk("bp_resp_held", 72'(resp_valid), 72'(1));
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk("bp_m_ce", 72'(m_ce), 72'(0));
            chk("bp_req_ready", 72'(req_ready), 72'(0));
            chk("bp_resp_data", resp_data, hold_data);
            chk("bp_resp_id", 72'(resp_id), 72'(hold_id));
            step();
        end
        resp_ready = 1'b1;
        repeat (6) step();
        req_valid = '0;
        repeat (5) step();
        chk("no_loss_no_dup", 72'(n_resp), 72'(n_acc));
        chk("stream_count", 72'(n_acc > 10), 72'(1));

        // extremes
        single_op("min_x_min", 0, 36'h800000000, 36'h800000000, 72'h400000000000000000);
        single_op("max_x_one", 3, 36'd34359738367, 36'd1, 72'd34359738367);

        // reset with two operations in flight
        req_valid = '1;
        repeat (3) step();
        resp_ready = 1'b0;
        @(negedge clk);
        chk("inflight_busy", 72'(busy), 72'(1));
        step();
        rstn = 1'b0;
        req_valid = '0;
        #1;
        chk("midreset_resp_valid", 72'(resp_valid), 72'(0));
        chk("midreset_busy", 72'(busy), 72'(0));
        step();
        step();
        rstn = 1'b1;
        resp_ready = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) cnt++;
            step();
        end
        chk("no_resp_after_reset", 72'(cnt), 72'(0));

        // spurious multiplier valid with an empty tag pipeline
        force_vo = 1'b1;
        step();
        force_vo = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("proto_err_sticky_%0d", c), 72'(proto_err), 72'(1));
            step();
        end
        rstn = 1'b0;
        #1;
        chk("proto_err_cleared", 72'(proto_err), 72'(0));
        step();
        rstn = 1'b1;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
